cnt_sched: RTL and testbench

CNT_SCHED -- requirements
Module: cnt_sched

---
 rtl/cnt_sched.sv | 104 ++++++++++
 tb/tb_cnt_sched.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/cnt_sched.sv
// Prescaled up-counter with one-shot/reload modes, pause, stop and done pulse.
// Terminal count reached PRESCALE*(lim+1) cycles after start absent pause.
module cnt_sched #(
  parameter int PRESCALE = 4
) (
  input  logic       clk,
  input  logic       res,
  input  logic       start,
  input  logic       stop,
  input  logic       pause,
  input  logic       auto,
  input  logic [3:0] limit,
  output logic [3:0] q,
  output logic       busy,
  output logic       done,
  output logic [3:0] passes
);

  localparam int PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  state_t        state, state_n;
  logic [PW-1:0] pre, pre_n;
  logic [3:0]    lim, lim_n;
  logic [3:0]    q_n, passes_n;
  logic          mode, mode_n;
  logic          done_n;

  always_ff @(posedge clk) begin
    if (res) begin
      state  <= IDLE;
      pre    <= '0;
      lim    <= '0;
      mode   <= 1'b0;
      q      <= '0;
      passes <= '0;
      done   <= 1'b0;
    end else begin
      state  <= state_n;
      pre    <= pre_n;
      lim    <= lim_n;
      mode   <= mode_n;
      q      <= q_n;
      passes <= passes_n;
      done   <= done_n;
    end
  end

  // PAUSE with pause low behaves exactly like RUN, so each paused
  // cycle costs exactly one cycle of delay.
  always_comb begin
    state_n  = state;
    pre_n    = pre;
    lim_n    = lim;
    mode_n   = mode;
    q_n      = q;
    passes_n = passes;
    done_n   = 1'b0;
    unique case (state)
      IDLE: begin
        if (start && !stop) begin
          lim_n    = limit;
          mode_n   = auto;
          q_n      = '0;
          pre_n    = '0;
          passes_n = '0;
          state_n  = RUN;
        end
      end
      RUN, PAUSE: begin
        if (stop) begin
          state_n = IDLE;
        end else if (pause) begin
          state_n = PAUSE;
        end else begin
          state_n = RUN;
          if (pre == PMAX) begin
            pre_n = '0;
            if (q != lim) begin
              q_n = q + 4'd1;
            end else begin
              done_n   = 1'b1;
              passes_n = (passes == 4'd15) ? passes : passes + 4'd1;
              if (mode) q_n = '0;
              else state_n = IDLE;
            end
          end else begin
            pre_n = pre + PW'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_cnt_sched.sv
// Directed vector bench for cnt_sched at PRESCALE=4.
module tb_cnt_sched;

  logic       clk = 1'b0;
  logic       res, start, stop, pause, auto;
  logic [3:0] limit;
  logic [3:0] q, passes;
  logic       busy, done;

  int checks = 0;
  int errors = 0;

  cnt_sched #(.PRESCALE(4)) dut (
    .clk(clk), .res(res), .start(start), .stop(stop),
    .pause(pause), .auto(auto), .limit(limit),
    .q(q), .busy(busy), .done(done), .passes(passes)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       r, s, p_stop, p, a;
    logic [3:0] lm;
    int         n;
    logic [3:0] eq;
    logic       eb, ed;
    logic [3:0] ep;
  } vec_t;

  vec_t v[$];

  function automatic vec_t mk(
    input logic r, s, st, p, a, input logic [3:0] lm,
    input int n, input logic [3:0] eq,
    input logic eb, ed, input logic [3:0] ep);
    vec_t t;
    t.r = r; t.s = s; t.p_stop = st; t.p = p; t.a = a;
    t.lm = lm; t.n = n; t.eq = eq; t.eb = eb; t.ed = ed; t.ep = ep;
    return t;
  endfunction

  task automatic drive(input logic r, s, st, p, a,
                       input logic [3:0] lm);
    res = r; start = s; stop = st; pause = p; auto = a; limit = lm;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  int dcount, maxq;

  initial begin
    drive(1, 0, 0, 0, 0, 0);
    // r s st p a lim  n  | q b d passes
    v.push_back(mk(1,0,0,0,0, 0, 1,  0,0,0, 0));
    v.push_back(mk(0,0,0,0,0, 0, 2,  0,0,0, 0));
    // one-shot, limit=3; limit/auto changes during run ignored
    v.push_back(mk(0,1,0,0,0, 3, 1,  0,1,0, 0));
    v.push_back(mk(0,0,0,0,1,15, 3,  0,1,0, 0));
    v.push_back(mk(0,0,0,0,1,15, 1,  1,1,0, 0));
    v.push_back(mk(0,0,0,0,1,15, 4,  2,1,0, 0));
    v.push_back(mk(0,0,0,0,1,15, 4,  3,1,0, 0));
    v.push_back(mk(0,0,0,0,1,15, 3,  3,1,0, 0));
    v.push_back(mk(0,0,0,0,0, 0, 1,  3,0,1, 1));
    v.push_back(mk(0,0,0,0,0, 0, 1,  3,0,0, 1));
    // reload, limit=2; start mid-run ignored
    v.push_back(mk(0,1,0,0,1, 2, 1,  0,1,0, 0));
    v.push_back(mk(0,0,0,0,0, 0,11,  2,1,0, 0));
    v.push_back(mk(0,0,0,0,0, 0, 1,  0,1,1, 1));
    v.push_back(mk(0,0,0,0,0, 0,12,  0,1,1, 2));
    v.push_back(mk(0,0,0,0,0, 0,12,  0,1,1, 3));
    v.push_back(mk(0,1,0,0,0, 0, 4,  1,1,0, 3));
    // reset mid-run, then idle without done
    v.push_back(mk(1,0,0,0,0, 0, 1,  0,0,0, 0));
    v.push_back(mk(0,0,0,0,0, 0,20,  0,0,0, 0));
    // pause 5 cycles in one-shot limit=1
    v.push_back(mk(0,1,0,0,0, 1, 1,  0,1,0, 0));
    v.push_back(mk(0,0,0,0,0, 0, 2,  0,1,0, 0));
    v.push_back(mk(0,0,0,1,0, 0, 5,  0,1,0, 0));
    v.push_back(mk(0,0,0,0,0, 0, 2,  1,1,0, 0));
    v.push_back(mk(0,0,0,0,0, 0, 3,  1,1,0, 0));
    v.push_back(mk(0,0,0,0,0, 0, 1,  1,0,1, 1));
    // stop at cycle 6 of limit=5; start+stop in IDLE
    v.push_back(mk(0,1,0,0,0, 5, 1,  0,1,0, 0));
    v.push_back(mk(0,0,0,0,0, 0, 5,  1,1,0, 0));
    v.push_back(mk(0,0,1,0,0, 0, 1,  1,0,0, 0));
    v.push_back(mk(0,0,0,0,0, 0,30,  1,0,0, 0));
    v.push_back(mk(0,1,1,0,1, 9, 1,  1,0,0, 0));
    v.push_back(mk(0,0,0,0,0, 0,10,  1,0,0, 0));
    // reload limit=0 saturation
    v.push_back(mk(0,1,0,0,1, 0, 1,  0,1,0, 0));
    v.push_back(mk(0,0,0,0,0, 0, 3,  0,1,0, 0));
    v.push_back(mk(0,0,0,0,0, 0, 1,  0,1,1, 1));
    v.push_back(mk(0,0,0,0,0, 0, 4,  0,1,1, 2));
    v.push_back(mk(0,0,0,0,0, 0,72,  0,1,1,15));
    v.push_back(mk(0,0,0,0,0, 0, 1,  0,1,0,15));

    @(posedge clk); #1;
    foreach (v[i]) begin
      drive(v[i].r, v[i].s, v[i].p_stop, v[i].p, v[i].a, v[i].lm);
      repeat (v[i].n) @(posedge clk);
      #1;
      checks++;
      if ({q, busy, done, passes} !== {v[i].eq, v[i].eb, v[i].ed, v[i].ep}) begin
        errors++;
        $display("FAIL vec%0d: got q=%0d busy=%0d done=%0d passes=%0d expected q=%0d busy=%0d done=%0d passes=%0d",
                 i, q, busy, done, passes, v[i].eq, v[i].eb, v[i].ed, v[i].ep);
      end
    end

    // one-shot limit=3: exactly one done pulse, q never past lim
    drive(1, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    drive(0, 1, 0, 0, 0, 3);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0);
    dcount = 0; maxq = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (done) dcount++;
      if (int'(q) > maxq) maxq = int'(q);
    end
    check("oneshot_done_count", dcount, 1);
    check("oneshot_max_q", maxq, 3);
    check("oneshot_passes", passes, 1);

    // stop while paused: idle, q held, no done
    drive(0, 1, 0, 0, 0, 2);
    @(posedge clk); #1;
    drive(0, 0, 0, 1, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    check("pause_busy", busy, 1);
    drive(0, 0, 1, 1, 0, 0);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0);
    dcount = 0;
    check("pstop_busy", busy, 0);
    repeat (20) begin
      @(posedge clk); #1;
      if (done || busy) dcount++;
    end
    check("pstop_quiet", dcount, 0);
    check("pstop_q", q, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
